// File: rtl/prio_irq_encoder_pkg.sv
// Shared types and constants for the priority interrupt encoder.
package prio_irq_encoder_pkg;

   // Two-state grant FSM
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Priority mode encodings for the mode input
   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prio_irq_encoder_prio_select.sv
// Combinational winner selection over the pending vector.
// Fixed mode: highest pending index wins.
// Round-robin mode: search starts at ptr and walks downward, wrapping modulo N.
module prio_select
   import prio_irq_encoder_pkg::*;
#(
   parameter  int unsigned OUT_LEN = 2,
   localparam int unsigned N       = 2 ** OUT_LEN
) (
   input  logic [N-1:0]       pending,
   input  logic [OUT_LEN-1:0] ptr,
   input  logic               mode,
   output logic [OUT_LEN-1:0] index,
   output logic               any
);

   logic [OUT_LEN-1:0] pos;

   // Later loop iterations overwrite earlier ones, so the last hit is the highest priority
   always_comb begin
      index = '0;
      pos   = '0;
      any   = |pending;
      if (mode == MODE_FIXED) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (pending[i]) begin
               index = OUT_LEN'(i);
            end
         end
      end else begin
         // offset N-1 is visited first, offset 0 (ptr itself) last
         for (int unsigned k = N; k > 0; k--) begin
            pos = ptr - OUT_LEN'(k - 1);
            if (pending[pos]) begin
               index = pos;
            end
         end
      end
   end

endmodule

// File: rtl/prio_irq_encoder.sv
// Priority interrupt encoder: latches level requests into a pending vector,
// grants one channel at a time and holds the grant until acknowledged.
module prio_irq_encoder
   import prio_irq_encoder_pkg::*;
#(
   parameter  int unsigned OUT_LEN = 2,
   localparam int unsigned N       = 2 ** OUT_LEN
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               mode,
   input  logic [N-1:0]       req,
   input  logic               ack,
   output logic               valid,
   output logic [OUT_LEN-1:0] idx,
   output logic [N-1:0]       pending
);

   state_t             state;
   logic [OUT_LEN-1:0] ptr;
   logic [OUT_LEN-1:0] sel_idx;
   logic               sel_any;
   logic               grant_mode;
   logic [N-1:0]       set_mask;
   logic [N-1:0]       clr_mask;

   prio_select #(
      .OUT_LEN(OUT_LEN)
   ) u_sel (
      .pending(pending),
      .ptr    (ptr),
      .mode   (mode),
      .index  (sel_idx),
      .any    (sel_any)
   );

   // Set and clear masks for the pending vector; set is applied after clear so it wins
   always_comb begin
      set_mask = en ? req : '0;
      clr_mask = '0;
      if (state == GRANT && ack) begin
         clr_mask[idx] = 1'b1;
      end
   end

   // Pending request register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~clr_mask) | set_mask;
      end
   end

   // Grant FSM with registered valid/idx and the round-robin pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         valid      <= 1'b0;
         idx        <= '0;
         ptr        <= '1;
         grant_mode <= MODE_FIXED;
      end else begin
         case (state)
            IDLE: begin
               if (en && sel_any) begin
                  state      <= GRANT;
                  valid      <= 1'b1;
                  idx        <= sel_idx;
                  grant_mode <= mode;
               end
            end
            GRANT: begin
               if (ack) begin
                  state <= IDLE;
                  valid <= 1'b0;
                  idx   <= '0;
                  // mode captured at grant time governs the pointer update
                  if (grant_mode == MODE_RR) begin
                     ptr <= idx - OUT_LEN'(1);
                  end
               end
            end
            default: begin
               state <= IDLE;
               valid <= 1'b0;
               idx   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prio_irq_encoder.sv
// Self-checking bench for prio_irq_encoder (OUT_LEN=2 with reference model, OUT_LEN=3 directed).
module tb_prio_irq_encoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       en, mode, ack;
   logic [3:0] req;
   logic       valid;
   logic [1:0] idx;
   logic [3:0] pending;

   logic       en3, mode3, ack3;
   logic [7:0] req3;
   logic       valid3;
   logic [2:0] idx3;
   logic [7:0] pending3;

   int chk = 0;
   int err = 0;
   int grants[$];

   // Reference model state for the OUT_LEN=2 instance
   logic [3:0] m_pend;
   logic       m_valid;
   logic [1:0] m_idx;
   logic [1:0] m_ptr;
   logic       m_gmode;

   prio_irq_encoder #(.OUT_LEN(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .req(req), .ack(ack),
      .valid(valid), .idx(idx), .pending(pending)
   );

   prio_irq_encoder #(.OUT_LEN(3)) dut3 (
      .clk(clk), .rst(rst), .en(en3), .mode(mode3), .req(req3), .ack(ack3),
      .valid(valid3), .idx(idx3), .pending(pending3)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk++;
      assert (obs === exp) else begin
         err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Winner by rule: fixed = highest pending index; rr = first pending at ptr, ptr-1, ... mod 4
   function automatic int model_sel(input logic [3:0] p, input logic [1:0] ptr, input logic md);
      if (!md) begin
         for (int i = 3; i >= 0; i--) begin
            if (p[i]) return i;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            int j;
            j = (int'(ptr) - k + 4) % 4;
            if (p[j]) return j;
         end
      end
      return 0;
   endfunction

   task automatic model_reset();
      m_pend  = 4'b0;
      m_valid = 1'b0;
      m_idx   = 2'd0;
      m_ptr   = 2'd3;
      m_gmode = 1'b0;
   endtask

   // Advance one clock: update model from inputs at the edge, then compare 1ns later
   task automatic tick();
      logic [3:0] setm, clrm;
      @(posedge clk);
      setm = en ? req : 4'b0;
      clrm = 4'b0;
      if (m_valid && ack) begin
         clrm[m_idx] = 1'b1;
         if (m_gmode) m_ptr = 2'((int'(m_idx) + 3) % 4);
         m_valid = 1'b0;
         m_idx   = 2'd0;
      end else if (!m_valid && en && m_pend != 4'b0) begin
         m_idx   = 2'(model_sel(m_pend, m_ptr, mode));
         m_valid = 1'b1;
         m_gmode = mode;
      end
      m_pend = (m_pend & ~clrm) | setm;
      #1;
      check("valid", 32'(valid), 32'(m_valid));
      check("idx", 32'(idx), 32'(m_idx));
      check("pending", 32'(pending), 32'(m_pend));
   endtask

   // Asynchronous reset between edges; outputs must clear without a clock edge
   task automatic do_reset();
      ack  = 1'b0;
      ack3 = 1'b0;
      rst  = 1'b1;
      #2;
      model_reset();
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_idx", 32'(idx), 32'd0);
      check("rst_pending", 32'(pending), 32'd0);
      check("rst_valid3", 32'(valid3), 32'd0);
      check("rst_pending3", 32'(pending3), 32'd0);
      rst = 1'b0;
   endtask

   // Acknowledge every grant on the following edge; stop once enough grants seen and idle
   task automatic run_grants(input int want, input int budget);
      grants.delete();
      for (int c = 0; c < budget && (grants.size() < want || valid); c++) begin
         tick();
         if (valid) grants.push_back(int'(idx));
         ack = valid;
      end
      ack = 1'b0;
      check("grant_count", 32'(grants.size()), 32'(want));
   endtask

   function automatic logic [31:0] grant_at(input int i);
      return (i < grants.size()) ? 32'(grants[i]) : 32'hFFFF_FFFF;
   endfunction

   initial begin
      int exp_rr[4];
      en = 0; mode = 0; req = 0; ack = 0;
      en3 = 0; mode3 = 0; req3 = 0; ack3 = 0;
      rst = 1'b1;
      do_reset();

      // Fixed mode, req=1001 held: always index 3, pending stays 1001
      mode = 1'b0; en = 1'b1; req = 4'b1001;
      run_grants(3, 30);
      for (int i = 0; i < 3; i++) check("fixed_seq", grant_at(i), 32'd3);
      check("fixed_pending", 32'(pending), 32'h9);

      // Round-robin, req=1001 held: 3,0,3,0 (pointer wraps after grant 0)
      do_reset();
      mode = 1'b1; en = 1'b1; req = 4'b1001;
      run_grants(4, 40);
      exp_rr = '{3, 0, 3, 0};
      for (int i = 0; i < 4; i++) check("rr_seq", grant_at(i), 32'(exp_rr[i]));

      // Single-cycle request, grant held for 5 cycles without ack
      do_reset();
      mode = 1'b0; en = 1'b1; req = 4'b0100;
      tick();
      req = 4'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_valid", 32'(valid), 32'd1);
         check("hold_idx", 32'(idx), 32'd2);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("ack_valid", 32'(valid), 32'd0);
      check("ack_pending", 32'(pending), 32'd0);

      // en=0 blocks capture; en dropping during GRANT keeps the grant
      do_reset();
      en = 1'b0; req = 4'b1111;
      for (int i = 0; i < 3; i++) tick();
      check("en0_pending", 32'(pending), 32'd0);
      check("en0_valid", 32'(valid), 32'd0);
      en = 1'b1;
      tick();
      tick();
      check("en1_grant_idx", 32'(idx), 32'd3);
      en = 1'b0; req = 4'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("en0_hold_valid", 32'(valid), 32'd1);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("en0_ack_valid", 32'(valid), 32'd0);

      // Reset mid-grant drops it at once; no grant afterwards with no requests
      do_reset();
      mode = 1'b0; en = 1'b1; req = 4'b0010;
      tick();
      req = 4'b0;
      tick();
      check("pre_rst_idx", 32'(idx), 32'd1);
      do_reset();
      for (int i = 0; i < 4; i++) tick();
      check("post_rst_valid", 32'(valid), 32'd0);

      // OUT_LEN=3 round-robin: 8'b1000_0001 pulsed once -> grants 7 then 0
      do_reset();
      en = 1'b0;
      mode3 = 1'b1; en3 = 1'b1; req3 = 8'h81;
      tick();
      req3 = 8'h00;
      grants.delete();
      for (int c = 0; c < 20 && (grants.size() < 2 || valid3); c++) begin
         tick();
         if (valid3) grants.push_back(int'(idx3));
         ack3 = valid3;
      end
      ack3 = 1'b0;
      check("w3_count", 32'(grants.size()), 32'd2);
      check("w3_first", grant_at(0), 32'd7);
      check("w3_second", grant_at(1), 32'd0);
      tick();
      check("w3_valid_end", 32'(valid3), 32'd0);
      check("w3_pending_end", 32'(pending3), 32'd0);
      en3 = 1'b0;

      // Randomised traffic against the model; mode only changes while idle
      do_reset();
      for (int c = 0; c < 400; c++) begin
         en  = ($urandom_range(0, 3) != 0);
         req = 4'($urandom_range(0, 15));
         ack = 1'($urandom_range(0, 1));
         if (!m_valid) mode = 1'($urandom_range(0, 1));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end

endmodule

// File: doc/prio_irq_encoder.md
PRIO_IRQ_ENCODER -- requirements
Module: prio_irq_encoder

Interface
REQ-001 Parameter OUT_LEN, default 2, sets index width; request count N = 2**OUT_LEN; legal range 1..6.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  enable; gates request capture and new grants.
REQ-005 mode  input  1  priority mode: 0 = fixed (highest index wins), 1 = round-robin.
REQ-006 req  input  N  level request lines, one per channel.
REQ-007 ack  input  1  consumer acknowledge of the current grant.
REQ-008 valid  output  1  grant present on idx.
REQ-009 idx  output  OUT_LEN  index of the granted channel.
REQ-010 pending  output  N  registered pending-request vector.

Function
REQ-011 The pending bit of channel i SHALL be set on each edge where en=1 and req[i]=1, and held until cleared by an acknowledged grant of channel i.
REQ-012 The FSM SHALL have exactly two states, IDLE and GRANT; reset state IDLE.
REQ-013 IDLE->GRANT: on an edge where en=1 and pending!=0, the block SHALL register the selected index into idx and set valid=1.
REQ-014 IDLE with en=0 or pending=0 SHALL remain IDLE with valid=0.
REQ-015 In GRANT, idx and valid SHALL hold stable until ack is sampled 1; en=0 SHALL NOT cancel an issued grant.
REQ-016 GRANT->IDLE: on an edge with ack=1 the block SHALL clear pending[idx], drive valid=0 and return to IDLE.
REQ-017 If req[idx]=1 and en=1 on the acknowledging edge, the set SHALL win and pending[idx] SHALL remain 1.
REQ-018 ack sampled in IDLE SHALL be ignored.
REQ-019 Whenever valid=0, idx SHALL read 0.
REQ-020 Fixed mode: selection SHALL search N-1 down to 0 and pick the first pending bit.
REQ-021 Round-robin mode: selection SHALL search ptr, ptr-1, ... wrapping modulo N, and pick the first pending bit.
REQ-022 ptr is an OUT_LEN-bit register, reset value N-1; on each acknowledged grant of index i in mode=1, ptr SHALL become (i-1) mod N; in mode=0 ptr SHALL hold.
REQ-023 mode is sampled only at the IDLE->GRANT edge; a change during GRANT SHALL affect the next selection only.
REQ-024 Latency: req rising before edge k -> pending set after k -> valid=1 after k+1 (if IDLE); ack at edge m -> valid=0 after m -> earliest next valid after m+1.

Reset
REQ-025 While rst=1: state=IDLE, valid=0, idx=0, pending=0, ptr=N-1, asynchronously and independent of clk.
REQ-026 Reset asserted mid-GRANT SHALL drop the grant immediately with no pending bit retained; first valid after release no earlier than the second edge after deassertion.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE, GRANT) and the mode constants MODE_FIXED=0, MODE_RR=1.
REQ-028 Selection logic SHALL be a combinational sub-module prio_select (inputs pending, ptr, mode; outputs index and any flag), parametrised by OUT_LEN.

Verification
REQ-029 OUT_LEN=2, mode=0, en=1, req=4'b1001 held, ack pulsed each grant -> idx sequence 3,3,3; pending stays 4'b1001.
REQ-030 OUT_LEN=2, mode=1, req=4'b1001 held, ack each grant -> idx sequence 3,0,3,0; ptr after grant 0 reads 3 (wrap).
REQ-031 req=4'b0100 one cycle, en=1, ack held 0 for 5 cycles -> valid=1, idx=2 stable all 5 cycles; ack=1 -> valid=0, pending=0.
REQ-032 en=0, req=4'b1111 -> pending=0, valid=0; en=1 while in GRANT then en=0 -> grant held until ack.
REQ-033 Grant active idx=1, assert rst between edges -> valid=0, idx=0, pending=0 immediately; after release, req=0 -> valid stays 0.
REQ-034 OUT_LEN=3, mode=1, req=8'b1000_0001 pulsed once -> grants 7 then 0, then valid=0 with pending=0.
